sample_window_stats: RTL and testbench

//  Downstream consumer of the 8-bit signed iterate stream from the seven-segment iterator stage.

---
 rtl/sample_flow_pkg.sv | 33 +++
 rtl/stats_fifo.sv | 71 +++++++
 rtl/sample_window_stats.sv | 150 +++++++++++++++
 tb/tb_sample_window_stats.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_flow_pkg.sv
// Shared definitions for the sample statistics path: record layout helpers and
// the accumulator state encoding.
package sample_flow_pkg;

  localparam int WRAPS_W = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } acc_state_t;

  function automatic int sum_w(input int width, input int window);
    return width + $clog2(window);
  endfunction

  // Record is packed as {wraps, min, max, sum} from MSB to LSB.
  function automatic int rec_w(input int width, input int window);
    return WRAPS_W + 2 * width + sum_w(width, window);
  endfunction

  function automatic int max_lsb(input int width, input int window);
    return sum_w(width, window);
  endfunction

  function automatic int min_lsb(input int width, input int window);
    return sum_w(width, window) + width;
  endfunction

  function automatic int wraps_lsb(input int width, input int window);
    return sum_w(width, window) + 2 * width;
  endfunction

endpackage

// File: rtl/stats_fifo.sv
// First-word-fall-through record FIFO. The head is held in a register so the
// outputs keep the last popped record once the FIFO runs empty.
module stats_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          valid,
  output logic          full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic [DW-1:0] head_reg;
  logic [DW-1:0] head_next;
  logic          pop_eff;
  logic          push_eff;

  assign valid    = (count_reg != '0);
  assign full     = (count_reg == CW'(DEPTH));
  assign pop_eff  = pop && valid;
  // A pop on a full FIFO frees the slot the push then lands in.
  assign push_eff = push && (!full || pop_eff);
  assign head     = head_reg;

  always_comb begin
    count_next = count_reg + CW'(push_eff) - CW'(pop_eff);
    head_next  = head_reg;
    if (pop_eff) begin
      if (count_reg > CW'(1))
        head_next = mem[rd_ptr_reg + AW'(1)];
      else if (push_eff)
        head_next = push_data;
    end else if (!valid && push_eff) begin
      head_next = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push_eff)
      mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      if (push_eff)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_eff)
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
      head_reg  <= head_next;
    end
  end

endmodule

// File: rtl/sample_window_stats.sv
// Per-window min/max/sum/wrap statistics over a signed sample stream, with
// completed records buffered in a small FWFT FIFO behind a valid/ready port.
module sample_window_stats
  import sample_flow_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int WINDOW    = 256,
  parameter  int WRAP_DROP = 32,
  parameter  int DEPTH     = 4,
  localparam int SUM_W     = sum_w(WIDTH, WINDOW)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_valid,
  input  logic signed [WIDTH-1:0] s_data,
  output logic                    r_valid,
  input  logic                    r_ready,
  output logic signed [WIDTH-1:0] r_min,
  output logic signed [WIDTH-1:0] r_max,
  output logic signed [SUM_W-1:0] r_sum,
  output logic [7:0]              r_wraps,
  output logic [7:0]              drop_count
);

  localparam int IDX_W   = $clog2(WINDOW);
  localparam int REC_W   = rec_w(WIDTH, WINDOW);
  localparam int MAX_LSB = max_lsb(WIDTH, WINDOW);
  localparam int MIN_LSB = min_lsb(WIDTH, WINDOW);
  localparam int WRP_LSB = wraps_lsb(WIDTH, WINDOW);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(WINDOW - 1);
  localparam logic signed [WIDTH:0] DROP_TH  = (WIDTH + 1)'(WRAP_DROP);

  acc_state_t              state_reg;
  acc_state_t              state_next;
  logic [IDX_W-1:0]        idx_reg;
  logic signed [WIDTH-1:0] min_reg;
  logic signed [WIDTH-1:0] max_reg;
  logic signed [SUM_W-1:0] sum_reg;
  logic [7:0]              wraps_reg;
  logic signed [WIDTH-1:0] prev_reg;
  logic                    prev_valid_reg;
  logic [7:0]              drop_count_reg;

  logic                    first_sample;
  logic                    close_sample;
  logic                    wrap_event;
  logic signed [WIDTH:0]   diff;
  logic signed [SUM_W-1:0] sample_ext;
  logic signed [WIDTH-1:0] min_next;
  logic signed [WIDTH-1:0] max_next;
  logic signed [SUM_W-1:0] sum_next;
  logic [7:0]              wraps_base;
  logic [7:0]              wraps_next;
  logic [REC_W-1:0]        push_rec;
  logic [REC_W-1:0]        head_rec;
  logic                    fifo_full;
  logic                    pop;

  // Accumulator FSM
  always_ff @(posedge clk) begin
    if (reset)
      state_reg <= ST_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (s_valid) state_next = ST_ACCUM;
      ST_ACCUM: if (close_sample) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    first_sample = (state_reg == ST_IDLE);
  end

  // One extra bit on the difference so full-scale swings compare correctly.
  always_comb begin
    diff         = {prev_reg[WIDTH-1], prev_reg} - {s_data[WIDTH-1], s_data};
    wrap_event   = prev_valid_reg && (diff >= DROP_TH);
    sample_ext   = {{(SUM_W - WIDTH){s_data[WIDTH-1]}}, s_data};
    close_sample = s_valid && (idx_reg == LAST_IDX);
    if (first_sample) begin
      min_next   = s_data;
      max_next   = s_data;
      sum_next   = sample_ext;
      wraps_base = 8'd0;
    end else begin
      min_next   = (s_data < min_reg) ? s_data : min_reg;
      max_next   = (s_data > max_reg) ? s_data : max_reg;
      sum_next   = sum_reg + sample_ext;
      wraps_base = wraps_reg;
    end
    wraps_next = (wrap_event && wraps_base != 8'hFF) ? wraps_base + 8'd1 : wraps_base;
    push_rec   = {wraps_next, min_next, max_next, sum_next};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_reg        <= '0;
      min_reg        <= '0;
      max_reg        <= '0;
      sum_reg        <= '0;
      wraps_reg      <= '0;
      prev_reg       <= '0;
      prev_valid_reg <= 1'b0;
    end else if (s_valid) begin
      idx_reg        <= idx_reg + IDX_W'(1);
      min_reg        <= min_next;
      max_reg        <= max_next;
      sum_reg        <= sum_next;
      wraps_reg      <= wraps_next;
      prev_reg       <= s_data;
      prev_valid_reg <= 1'b1;
    end
  end

  stats_fifo #(
    .DW    (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (close_sample),
    .push_data (push_rec),
    .pop       (r_ready),
    .head      (head_rec),
    .valid     (r_valid),
    .full      (fifo_full)
  );

  assign pop = r_valid && r_ready;

  always_ff @(posedge clk) begin
    if (reset)
      drop_count_reg <= '0;
    else if (close_sample && fifo_full && !pop && drop_count_reg != 8'hFF)
      drop_count_reg <= drop_count_reg + 8'd1;
  end

  assign drop_count = drop_count_reg;
  assign r_sum      = head_rec[0 +: SUM_W];
  assign r_max      = head_rec[MAX_LSB +: WIDTH];
  assign r_min      = head_rec[MIN_LSB +: WIDTH];
  assign r_wraps    = head_rec[WRP_LSB +: 8];

endmodule

// File: tb/tb_sample_window_stats.sv
// Randomized bench for sample_window_stats against a queue-based window/FIFO model.
module tb_sample_window_stats;

  localparam int WIDTH     = 8;
  localparam int WINDOW    = 8;
  localparam int WRAP_DROP = 32;
  localparam int DEPTH     = 4;
  localparam int SUM_W     = WIDTH + $clog2(WINDOW);

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    s_valid = 1'b0;
  logic signed [WIDTH-1:0] s_data = '0;
  logic                    r_valid;
  logic                    r_ready = 1'b0;
  logic signed [WIDTH-1:0] r_min;
  logic signed [WIDTH-1:0] r_max;
  logic signed [SUM_W-1:0] r_sum;
  logic [7:0]              r_wraps;
  logic [7:0]              drop_count;

  sample_window_stats #(
    .WIDTH     (WIDTH),
    .WINDOW    (WINDOW),
    .WRAP_DROP (WRAP_DROP),
    .DEPTH     (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .r_valid    (r_valid),
    .r_ready    (r_ready),
    .r_min      (r_min),
    .r_max      (r_max),
    .r_sum      (r_sum),
    .r_wraps    (r_wraps),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mn;
    int mx;
    int sm;
    int wr;
  } rec_t;

  rec_t q[$];
  rec_t last_rec;
  int   win[$];
  int   win_wraps;
  int   prev;
  bit   prev_valid;
  int   drops;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    win.delete();
    last_rec   = '{0, 0, 0, 0};
    win_wraps  = 0;
    prev       = 0;
    prev_valid = 0;
    drops      = 0;
  endtask

  // Applies one accepted sample; returns the finished record when the window fills.
  task automatic model_sample(input int d, output bit got, output rec_t rec);
    got = 0;
    rec = '{0, 0, 0, 0};
    if (prev_valid && (prev - d) >= WRAP_DROP && win_wraps < 255)
      win_wraps++;
    prev       = d;
    prev_valid = 1;
    win.push_back(d);
    if (win.size() == WINDOW) begin
      rec.mn = win[0];
      rec.mx = win[0];
      rec.sm = 0;
      foreach (win[i]) begin
        if (win[i] < rec.mn) rec.mn = win[i];
        if (win[i] > rec.mx) rec.mx = win[i];
        rec.sm += win[i];
      end
      rec.wr    = win_wraps;
      win_wraps = 0;
      win.delete();
      got = 1;
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    s_valid = 1'b0;
    r_ready = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    model_clear();
  endtask

  // One clock: compare outputs before the edge, advance DUT and model, compare drop count.
  task automatic cycle(input bit v, input int d, input bit rd);
    rec_t cur;
    rec_t rec;
    bit   got;
    bit   pop;
    s_valid = v;
    s_data  = WIDTH'(d);
    r_ready = rd;
    cur = (q.size() != 0) ? q[0] : last_rec;
    check("r_valid", int'(r_valid), int'(q.size() != 0));
    check("r_min", int'(r_min), cur.mn);
    check("r_max", int'(r_max), cur.mx);
    check("r_sum", int'(r_sum), cur.sm);
    check("r_wraps", int'(r_wraps), cur.wr);
    pop = rd && (q.size() != 0);
    got = 0;
    if (v) model_sample(d, got, rec);
    @(posedge clk);
    #1;
    if (pop) begin
      last_rec = q[0];
      void'(q.pop_front());
    end
    if (got) begin
      if (q.size() < DEPTH) q.push_back(rec);
      else if (drops < 255) drops++;
    end
    check("drop_count", int'(drop_count), drops);
  endtask

  function automatic int rand_sample();
    case ($urandom_range(3))
      0:       return 127 - int'($urandom_range(3));
      1:       return -128 + int'($urandom_range(3));
      default: return int'($urandom_range(255)) - 128;
    endcase
  endfunction

  int n;
  int t3[8] = '{40, 50, -20, 10, -21, 0, 0, 0};
  int tb[8] = '{0, -32, -1, -32, -64, -64, -64, -64};

  initial begin
    s_valid = 1'b0;
    model_clear();
    // Test 1: reset state
    do_reset();
    check("t1_valid", int'(r_valid), 0);
    check("t1_min", int'(r_min), 0);
    check("t1_max", int'(r_max), 0);
    check("t1_sum", int'(r_sum), 0);
    check("t1_wraps", int'(r_wraps), 0);
    check("t1_drop", int'(drop_count), 0);

    // Test 2: ramp 0..7
    for (int i = 0; i < 8; i++) cycle(1, i, 0);
    check("t2_valid", int'(r_valid), 1);
    check("t2_min", int'(r_min), 0);
    check("t2_max", int'(r_max), 7);
    check("t2_sum", int'(r_sum), 28);
    check("t2_wraps", int'(r_wraps), 0);
    cycle(0, 0, 1);

    // Test 3: drops of 70 and 31
    for (int i = 0; i < 8; i++) cycle(1, t3[i], 0);
    check("t3_min", int'(r_min), -21);
    check("t3_max", int'(r_max), 50);
    check("t3_sum", int'(r_sum), 59);
    check("t3_wraps", int'(r_wraps), 1);
    cycle(0, 0, 1);

    // Threshold boundary: drops of exactly 32 count, 31 do not
    for (int i = 0; i < 8; i++) cycle(1, tb[i], 0);
    check("tb_wraps", int'(r_wraps), 2);
    cycle(0, 0, 1);

    // Test 4: five windows into a four-deep FIFO
    for (int w = 0; w < 5; w++)
      for (int i = 0; i < 8; i++) cycle(1, rand_sample(), 0);
    check("t4_drop", int'(drop_count), 1);
    check("t4_valid", int'(r_valid), 1);
    n = 0;
    repeat (6) begin
      if (r_valid) n++;
      cycle(0, 0, 1);
    end
    check("t4_drained", n, 4);
    check("t4_empty", int'(r_valid), 0);

    // Test 5: full FIFO, closing sample coincides with a pop
    for (int i = 0; i < 39; i++) cycle(1, rand_sample(), 0);
    cycle(1, rand_sample(), 1);
    check("t5_drop", int'(drop_count), 1);
    n = 0;
    repeat (6) begin
      if (r_valid) n++;
      cycle(0, 0, 1);
    end
    check("t5_drained", n, 4);

    // Test 6: reset mid-window, then gapped samples after reset
    for (int i = 0; i < 3; i++) cycle(1, 100, 0);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(3)) cycle(0, rand_sample(), 0);
      cycle(1, -100, 0);
    end
    check("t6_valid", int'(r_valid), 1);
    check("t6_min", int'(r_min), -100);
    check("t6_max", int'(r_max), -100);
    check("t6_sum", int'(r_sum), -800);
    check("t6_wraps", int'(r_wraps), 0);
    check("t6_drop", int'(drop_count), 0);

    // Random traffic
    for (int i = 0; i < 600; i++)
      cycle(($urandom_range(3) != 0), rand_sample(), ($urandom_range(2) == 0));
    repeat (8) cycle(0, 0, 1);
    check("end_empty", int'(r_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
